// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

   // A fetch is always a 4-byte access.
   localparam logic [2:0] FETCH_SIZE = 3'd2;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// rtl/mem_bus_arbiter_arb_pick.sv - combinational winner select between fetch and data requests
module arb_pick
   import mem_bus_arbiter_pkg::*;
(
   input  logic i_ivalid,
   input  logic i_dvalid,
   input  logic i_prio,
   output logic o_owner,
   output logic o_valid
);

   always_comb begin
      o_valid = i_ivalid | i_dvalid;
      o_owner = OWN_I;
      if (i_ivalid & i_dvalid) begin
         o_owner = i_prio;
      end else if (i_dvalid) begin
         o_owner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one single-beat memory port between fetch and data buses
// Optional ARB_ROUND_ROBIN_EN: alternating priority on simultaneous requests (default: data wins).
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ireq_valid,
   input  logic [ADDR_W-1:0] ireq_addr,
   output logic              iresp_data_ok,
   output logic [31:0]       iresp_data,
   input  logic              dreq_valid,
   input  logic [ADDR_W-1:0] dreq_addr,
   input  logic [2:0]        dreq_size,
   input  logic [7:0]        dreq_strobe,
   input  logic [DATA_W-1:0] dreq_data,
   output logic              dresp_data_ok,
   output logic [DATA_W-1:0] dresp_data,
   output logic              mreq_valid,
   output logic [ADDR_W-1:0] mreq_addr,
   output logic [2:0]        mreq_size,
   output logic [7:0]        mreq_strobe,
   output logic [DATA_W-1:0] mreq_data,
   input  logic              mresp_valid,
   input  logic [DATA_W-1:0] mresp_data
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   arb_owner_t        r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_size;
   logic [7:0]        r_strobe;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_resp;
   logic              w_prio;
   logic              w_grant_owner;
   logic              w_grant_valid;
   logic              w_capture;
   logic              w_complete;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_prio;

   // After each grant the other requester gets precedence on the next tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio <= OWN_D;
      end else if (w_capture) begin
         r_prio <= ~w_grant_owner;
      end
   end

   assign w_prio = r_prio;
`else
   assign w_prio = OWN_D;
`endif

   arb_pick u_pick (
      .i_ivalid (ireq_valid),
      .i_dvalid (dreq_valid),
      .i_prio   (w_prio),
      .o_owner  (w_grant_owner),
      .o_valid  (w_grant_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      mreq_valid    = 1'b0;
      iresp_data_ok = 1'b0;
      dresp_data_ok = 1'b0;
      w_capture     = 1'b0;
      w_complete    = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            mreq_valid = 1'b1;
            if (mresp_valid) begin
               w_complete  = 1'b1;
               w_state_nxt = ARB_DONE;
            end
         end
         ARB_DONE: begin
            iresp_data_ok = (r_owner == OWN_I);
            dresp_data_ok = (r_owner == OWN_D);
            w_state_nxt   = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Request fields are frozen at grant so the memory sees a stable request while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner  <= OWN_I;
         r_addr   <= '0;
         r_size   <= '0;
         r_strobe <= '0;
         r_data   <= '0;
         r_resp   <= '0;
      end else begin
         if (w_capture) begin
            r_owner <= arb_owner_t'(w_grant_owner);
            if (w_grant_owner == OWN_D) begin
               r_addr   <= dreq_addr;
               r_size   <= dreq_size;
               r_strobe <= dreq_strobe;
               r_data   <= dreq_data;
            end else begin
               r_addr   <= ireq_addr;
               r_size   <= FETCH_SIZE;
               r_strobe <= '0;
               r_data   <= '0;
            end
         end
         if (w_complete) begin
            r_resp <= mresp_data;
         end
      end
   end

   assign mreq_addr   = r_addr;
   assign mreq_size   = r_size;
   assign mreq_strobe = r_strobe;
   assign mreq_data   = r_data;
   assign iresp_data  = r_addr[2] ? r_resp[63:32] : r_resp[31:0];
   assign dresp_data  = r_resp;

endmodule
